// File: rtl/seg7_scan_mux.sv
// Four-digit multiplexed seven-segment driver with frame-synchronous shadow
// registers and per-slot PWM dimming; all display lines are active-low.
module seg7_scan_mux #(
    parameter int unsigned DIM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_display,
    input  logic [15:0]         digits_in,
    input  logic [3:0]          blank_in,
    input  logic [3:0]          dp_in,
    input  logic                load,
    input  logic [DIM_BITS-1:0] brightness,
    output logic [3:0]          anodos,
    output logic [7:0]          segmentos,
    output logic                frame_done
);

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        unique case (nib)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    logic [1:0]          idx_q, idx_d;
    logic [DIM_BITS-1:0] dim_q, dim_d;
    logic [15:0]         pend_digits_q, pend_digits_d;
    logic [3:0]          pend_blank_q, pend_blank_d;
    logic [3:0]          pend_dp_q, pend_dp_d;
    logic                pend_valid_q, pend_valid_d;
    logic [15:0]         act_digits_q, act_digits_d;
    logic [3:0]          act_blank_q, act_blank_d;
    logic [3:0]          act_dp_q, act_dp_d;
    logic [3:0]          anodos_q, anodos_d;
    logic [7:0]          segs_q, segs_d;
    logic                frame_done_q;
    logic                boundary;
    logic                slot_on;
    logic [3:0]          cur_digit;

    always_comb begin
        boundary      = tick_display && (idx_q == 2'd3);
        idx_d         = tick_display ? idx_q + 2'd1 : idx_q;
        dim_d         = tick_display ? '0 : dim_q + DIM_BITS'(1);

        pend_digits_d = pend_digits_q;
        pend_blank_d  = pend_blank_q;
        pend_dp_d     = pend_dp_q;
        pend_valid_d  = pend_valid_q;
        act_digits_d  = act_digits_q;
        act_blank_d   = act_blank_q;
        act_dp_d      = act_dp_q;

        // Transfer uses the old pending copy, so a coincident load waits a frame.
        if (boundary && pend_valid_q) begin
            act_digits_d = pend_digits_q;
            act_blank_d  = pend_blank_q;
            act_dp_d     = pend_dp_q;
            pend_valid_d = 1'b0;
        end
        if (load) begin
            pend_digits_d = digits_in;
            pend_blank_d  = blank_in;
            pend_dp_d     = dp_in;
            pend_valid_d  = 1'b1;
        end

        slot_on   = (brightness == {DIM_BITS{1'b1}}) || (dim_q < brightness);
        cur_digit = act_digits_q[{idx_q, 2'b00} +: 4];
        anodos_d  = 4'b1111;
        segs_d    = 8'hFF;
        if (slot_on && !act_blank_q[idx_q]) begin
            anodos_d = ~(4'b0001 << idx_q);
            segs_d   = {~act_dp_q[idx_q], ~hex7(cur_digit)};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q         <= 2'd0;
            dim_q         <= '0;
            pend_digits_q <= 16'h0000;
            pend_blank_q  <= 4'b1111;
            pend_dp_q     <= 4'b0000;
            pend_valid_q  <= 1'b0;
            act_digits_q  <= 16'h0000;
            act_blank_q   <= 4'b1111;
            act_dp_q      <= 4'b0000;
            anodos_q      <= 4'b1111;
            segs_q        <= 8'hFF;
            frame_done_q  <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            dim_q         <= dim_d;
            pend_digits_q <= pend_digits_d;
            pend_blank_q  <= pend_blank_d;
            pend_dp_q     <= pend_dp_d;
            pend_valid_q  <= pend_valid_d;
            act_digits_q  <= act_digits_d;
            act_blank_q   <= act_blank_d;
            act_dp_q      <= act_dp_d;
            anodos_q      <= anodos_d;
            segs_q        <= segs_d;
            frame_done_q  <= boundary;
        end
    end

    assign anodos     = anodos_q;
    assign segmentos  = segs_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux: frame sync, shadow loading, PWM, blanking
// and asynchronous reset, with hand-computed segment patterns.
module tb_seg7_scan_mux;

    logic        clk;
    logic        rst;
    logic        tick_display;
    logic [15:0] digits_in;
    logic [3:0]  blank_in;
    logic [3:0]  dp_in;
    logic        load;
    logic [3:0]  brightness;
    logic [3:0]  anodos;
    logic [7:0]  segmentos;
    logic        frame_done;

    int          n_checks;
    int          n_errors;
    logic [1:0]  m_idx;

    seg7_scan_mux #(.DIM_BITS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_display (tick_display),
        .digits_in    (digits_in),
        .blank_in     (blank_in),
        .dp_in        (dp_in),
        .load         (load),
        .brightness   (brightness),
        .anodos       (anodos),
        .segmentos    (segmentos),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic clk_cycle(input logic t, input logic ld);
        tick_display = t;
        load         = ld;
        @(posedge clk);
        #1;
        tick_display = 1'b0;
        load         = 1'b0;
    endtask

    // One 4-clk scan slot: tick, then check the newly selected slot's outputs.
    task automatic slot(input logic ld, input logic chk, input logic [3:0] ea,
                        input logic [7:0] es);
        logic bnd;
        bnd = (m_idx == 2'd3);
        clk_cycle(1'b1, ld);
        m_idx = m_idx + 2'd1;
        check_eq("frame_done", {7'd0, frame_done}, {7'd0, bnd});
        clk_cycle(1'b0, 1'b0);
        check_eq("frame_done_clr", {7'd0, frame_done}, 8'd0);
        if (chk) begin
            check_eq("anodos", {4'd0, anodos}, {4'd0, ea});
            check_eq("segmentos", segmentos, es);
        end
        clk_cycle(1'b0, 1'b0);
        clk_cycle(1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] an_on;
        logic       exp_on;
        int         low_cnt;

        n_checks     = 0;
        n_errors     = 0;
        m_idx        = 2'd0;
        rst          = 1'b0;
        tick_display = 1'b0;
        load         = 1'b0;
        digits_in    = 16'h0000;
        blank_in     = 4'b0000;
        dp_in        = 4'b0000;
        brightness   = 4'hF;

        // Reset state, then 8 ticks with the reset-blank active copy.
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("rst_anodos", {4'd0, anodos}, 8'h0F);
        check_eq("rst_segs", segmentos, 8'hFF);
        check_eq("rst_frame_done", {7'd0, frame_done}, 8'd0);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) slot(1'b0, 1'b1, 4'b1111, 8'hFF);

        // Load 1234 with dp on digit 0: dark frame, then visible frames.
        digits_in = 16'h1234;
        blank_in  = 4'b0000;
        dp_in     = 4'b0001;
        clk_cycle(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) slot(1'b0, 1'b1, 4'b1111, 8'hFF);
        slot(1'b0, 1'b1, 4'b1110, 8'h19);
        slot(1'b0, 1'b1, 4'b1101, 8'hB0);
        slot(1'b0, 1'b1, 4'b1011, 8'hA4);
        slot(1'b0, 1'b1, 4'b0111, 8'hF9);
        slot(1'b0, 1'b1, 4'b1110, 8'h19);

        // Last load wins; a load coincident with the boundary waits a frame.
        dp_in     = 4'b0000;
        digits_in = 16'hAAAA;
        clk_cycle(1'b0, 1'b1);
        digits_in = 16'hBBBB;
        clk_cycle(1'b0, 1'b1);
        slot(1'b0, 1'b1, 4'b1101, 8'hB0);
        slot(1'b0, 1'b1, 4'b1011, 8'hA4);
        slot(1'b0, 1'b1, 4'b0111, 8'hF9);
        digits_in = 16'hCCCC;
        slot(1'b1, 1'b1, 4'b1110, 8'h83);
        slot(1'b0, 1'b1, 4'b1101, 8'h83);
        slot(1'b0, 1'b1, 4'b1011, 8'h83);
        slot(1'b0, 1'b1, 4'b0111, 8'h83);
        slot(1'b0, 1'b1, 4'b1110, 8'hC6);
        slot(1'b0, 1'b1, 4'b1101, 8'hC6);

        // PWM at brightness 4: on for dim_cnt 0..3 of each 16 clks.
        brightness = 4'h4;
        clk_cycle(1'b1, 1'b0);
        m_idx   = m_idx + 2'd1;
        an_on   = ~(4'b0001 << m_idx);
        low_cnt = 0;
        for (int j = 0; j < 64; j++) begin
            clk_cycle(1'b0, 1'b0);
            exp_on = (j % 16) < 4;
            check_eq("pwm_anodos", {4'd0, anodos}, {4'd0, exp_on ? an_on : 4'b1111});
            check_eq("pwm_segs", segmentos, exp_on ? 8'hC6 : 8'hFF);
            if (anodos != 4'b1111) low_cnt++;
        end
        check_eq("pwm_low_count", 8'(low_cnt), 8'd16);
        brightness = 4'h0;
        for (int j = 0; j < 20; j++) begin
            clk_cycle(1'b0, 1'b0);
            check_eq("dark_anodos", {4'd0, anodos}, 8'h0F);
        end

        // Blank digits 1 and 3 of 5678.
        brightness = 4'hF;
        digits_in  = 16'h5678;
        blank_in   = 4'b1010;
        clk_cycle(1'b0, 1'b1);
        while (m_idx != 2'd3) slot(1'b0, 1'b0, 4'b1111, 8'hFF);
        slot(1'b0, 1'b1, 4'b1110, 8'h80);
        slot(1'b0, 1'b1, 4'b1111, 8'hFF);
        slot(1'b0, 1'b1, 4'b1011, 8'h82);
        slot(1'b0, 1'b1, 4'b1111, 8'hFF);
        slot(1'b0, 1'b1, 4'b1110, 8'h80);

        // Asynchronous reset mid-frame with pending data.
        digits_in = 16'h9999;
        blank_in  = 4'b0000;
        clk_cycle(1'b0, 1'b1);
        slot(1'b0, 1'b1, 4'b1111, 8'hFF);
        slot(1'b0, 1'b1, 4'b1011, 8'h82);
        #3;
        rst = 1'b0;
        #1;
        check_eq("async_anodos", {4'd0, anodos}, 8'h0F);
        check_eq("async_segs", segmentos, 8'hFF);
        check_eq("async_frame_done", {7'd0, frame_done}, 8'd0);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        m_idx = 2'd0;
        for (int i = 0; i < 8; i++) slot(1'b0, 1'b1, 4'b1111, 8'hFF);
        digits_in = 16'h0000;
        clk_cycle(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) slot(1'b0, 1'b1, 4'b1111, 8'hFF);
        slot(1'b0, 1'b1, 4'b1110, 8'hC0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Time-multiplexed 4-digit seven-segment scan driver.
- Sits downstream of the banner/shift-register stage, which supplies four hex nibbles plus per-digit blank and decimal-point flags.
- Holds a frame-synchronous shadow copy of the digit data so the display never tears mid-frame.
- Sequences active-low anode and segment lines, with per-slot PWM dimming.
- Scan rate comes from the clk_div tick_display strobe.

Parameters:
DIM_BITS, 4, width of the brightness input and of the per-slot PWM counter.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous reset, active-low (asserted when 0).
tick_display  in  1  one-clk strobe from clk_div; advances the scan slot.
digits_in  in  16  digit nibbles; [3:0] = digit 0 (rightmost, anodos[0]), [15:12] = digit 3.
blank_in  in  4  per-digit blank; 1 = digit dark.
dp_in  in  4  per-digit decimal point; 1 = dp lit.
load  in  1  one-clk strobe; captures digits_in, blank_in and dp_in into the pending register.
brightness  in  DIM_BITS  duty control; 0 = dark, all-ones = full on.
anodos  out  4  active-low anode enables, registered.
segmentos  out  8  active-low segments {dp,g,f,e,d,c,b,a}, registered.
frame_done  out  1  one-clk pulse when scan wraps 3->0.

Behaviour:
- Reset (rst=0, async):
  - anodos=4'b1111, segmentos=8'hFF, frame_done=0.
  - scan index=0, dim_cnt=0, pending_valid=0.
  - active digits=16'h0000, active blank=4'b1111, active dp=4'b0000.
- Release is synchronous to clk. No output changes until the first clk edge after rst=1.
- Scan index (2 bits):
  - Increments mod 4 on each cycle with tick_display=1.
  - Otherwise holds.
  - dim_cnt clears to 0 on every tick.
- Load and shadow transfer:
  - load=1 captures the inputs into pending and sets pending_valid=1. A repeated load before transfer overwrites pending (last wins).
  - Frame boundary = cycle where tick_display=1 and index==3. On that cycle, if pending_valid, pending copies to active and pending_valid clears.
  - load and boundary in the same cycle: the old pending transfers, the new data is captured into pending with pending_valid=1, and it transfers at the next boundary.
  - load with pending_valid=0 at a boundary: the new data is not transferred this frame.
- frame_done: registered. It equals 1 for exactly the cycle after the boundary cycle.
- PWM:
  - dim_cnt (DIM_BITS) increments every clk and wraps freely within a slot.
  - Slot on when brightness == all-ones, or when dim_cnt < brightness (unsigned compare).
- Output register, updated every clk from the current index i and dim_cnt:
  - If the slot is on and active blank[i]==0:
    - anodos = ~(4'b0001 << i).
    - segmentos[6:0] = ~hex7(active digit i).
    - segmentos[7] = ~dp[i].
  - Else anodos=4'b1111 and segmentos=8'hFF.
  - Latency: 1 clk from an index or dim_cnt change to the outputs.
- hex7 encoding, {g..a} active-high before inversion:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Never more than one anode low at a time. All anodes are high whenever the blanking or PWM condition applies.
- rst asserted mid-frame: everything returns immediately to reset values, and any pending data is discarded.

Test Plan:
- Reset release, brightness=4'hF, no load, 8 ticks -> anodos=4'b1111, segmentos=8'hFF throughout (reset blank); frame_done pulses after the 4th and 8th ticks.
- load digits_in=16'h1234, blank_in=0, dp_in=4'b0001, brightness=4'hF; run 2 frames.
  - First frame stays dark.
  - Second frame: slot0 anodos=4'b1110, segmentos=8'h19 ("4"+dp); slot1 4'b1101/8'hB0; slot2 4'b1011/8'hA4; slot3 4'b0111/8'hF9.
- load 16'hAAAA then 16'hBBBB before the boundary, and a third load 16'hCCCC coincident with the boundary tick.
  - Next frame shows 8'h83 ("b") on all digits.
  - The following frame shows 8'hC6 ("C").
- brightness=4'h4, one slot held for 64 clks with blank=0 -> the anode is low for exactly 4 of every 16 clks (dim_cnt 0..3, counted from slot start); brightness=0 -> all anodes high.
- blank_in=4'b1010 loaded, brightness=4'hF -> anodos never takes 4'b1101 or 4'b0111; digits 0 and 2 are driven normally.
- Assert rst=0 asynchronously between clk edges mid-frame with pending_valid=1 -> outputs go to 4'b1111/8'hFF before the next edge; after release the display stays dark until a new load plus boundary.
